// File: rtl/mem_swap_pkg.sv
// Shared types for the memory-swap engine: command opcodes, FSM states and
// RAM port source-select codes.
package mem_swap_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_FILL = 2'd1,
    OP_SWAP = 2'd2,
    OP_RSVD = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD_A,
    ST_RD_B,
    ST_WR_A,
    ST_WR_B,
    ST_DONE
  } state_t;

  localparam logic [1:0] SEL_USER = 2'd0;
  localparam logic [1:0] SEL_FILL = 2'd1;
  localparam logic [1:0] SEL_SWAP = 2'd2;

  // The user port owns the RAM only while idle; otherwise the latched op picks the engine source.
  function automatic logic [1:0] port_sel(input state_t st, input op_t op);
    if (st == ST_IDLE)
      return SEL_USER;
    else if (op == OP_FILL)
      return SEL_FILL;
    else
      return SEL_SWAP;
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Combinational selector of the RAM port source: user pass-through, fill
// sequencer or swap sequencer.
module mem_port_mux
  import mem_swap_pkg::*;
#(
  parameter int addr_w_N    = 7,
  parameter int data_w_Bits = 8
) (
  input  logic [1:0]             i_sel,
  input  logic                   i_usr_we,
  input  logic [addr_w_N-1:0]    i_usr_addr_w,
  input  logic [addr_w_N-1:0]    i_usr_addr_r,
  input  logic [data_w_Bits-1:0] i_usr_data_w,
  input  logic                   i_fill_we,
  input  logic [addr_w_N-1:0]    i_fill_addr,
  input  logic [data_w_Bits-1:0] i_fill_data_w,
  input  logic                   i_swap_we,
  input  logic [addr_w_N-1:0]    i_swap_addr_w,
  input  logic [addr_w_N-1:0]    i_swap_addr_r,
  input  logic [data_w_Bits-1:0] i_swap_data_w,
  output logic                   o_mem_we,
  output logic [addr_w_N-1:0]    o_mem_addr_w,
  output logic [addr_w_N-1:0]    o_mem_addr_r,
  output logic [data_w_Bits-1:0] o_mem_data_w
);

  always_comb begin
    o_mem_we     = i_usr_we;
    o_mem_addr_w = i_usr_addr_w;
    o_mem_addr_r = i_usr_addr_r;
    o_mem_data_w = i_usr_data_w;
    case (i_sel)
      SEL_FILL: begin
        o_mem_we     = i_fill_we;
        o_mem_addr_w = i_fill_addr;
        o_mem_addr_r = i_fill_addr;
        o_mem_data_w = i_fill_data_w;
      end
      SEL_SWAP: begin
        o_mem_we     = i_swap_we;
        o_mem_addr_w = i_swap_addr_w;
        o_mem_addr_r = i_swap_addr_r;
        o_mem_data_w = i_swap_data_w;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_swap_ctrl.sv
// Memory-swap engine: passes user accesses through when idle, otherwise
// sequences a block SWAP between two ranges or a FILL of one range.
module mem_swap_ctrl
  import mem_swap_pkg::*;
#(
  parameter int addr_w_N    = 7,
  parameter int data_w_Bits = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   usr_we,
  input  logic [addr_w_N-1:0]    usr_addr_w,
  input  logic [addr_w_N-1:0]    usr_addr_r,
  input  logic [data_w_Bits-1:0] usr_data_w,
  output logic                   usr_ready,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [addr_w_N-1:0]    cmd_addr_a,
  input  logic [addr_w_N-1:0]    cmd_addr_b,
  input  logic [addr_w_N:0]      cmd_len,
  input  logic [data_w_Bits-1:0] cmd_fill,
  output logic                   mem_we,
  output logic [addr_w_N-1:0]    mem_addr_w,
  output logic [addr_w_N-1:0]    mem_addr_r,
  output logic [data_w_Bits-1:0] mem_data_w,
  input  logic [data_w_Bits-1:0] mem_data_r,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [addr_w_N:0] DEPTH   = {1'b1, {addr_w_N{1'b0}}};
  localparam logic [addr_w_N:0] IDX_ONE = 1;

  state_t                 r_state;
  op_t                    r_op;
  logic [addr_w_N-1:0]    r_addr_a;
  logic [addr_w_N-1:0]    r_addr_b;
  logic [addr_w_N:0]      r_len;
  logic [addr_w_N:0]      r_idx;
  logic [data_w_Bits-1:0] r_fill;
  logic [data_w_Bits-1:0] r_tmp_a;
  logic                   r_done;
  logic                   r_err;

  op_t                    w_cmd_op;
  logic                   w_idle;
  logic [addr_w_N-1:0]    w_dist;
  logic                   w_len_nz;
  logic                   w_overlap;
  logic                   w_reject;
  logic                   w_last;
  logic [addr_w_N-1:0]    w_addr_ai;
  logic [addr_w_N-1:0]    w_addr_bi;
  logic [1:0]             w_sel;

  assign w_cmd_op  = op_t'(cmd_op);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_len_nz  = (cmd_len != '0);
  // Forward distance B-A on the address ring; the ranges are disjoint only if B
  // starts at or past A's end and A starts at or past B's end going round.
  assign w_dist    = cmd_addr_b - cmd_addr_a;
  assign w_overlap = ({1'b0, w_dist} < cmd_len) || ({1'b0, w_dist} > (DEPTH - cmd_len));
  assign w_reject  = (w_cmd_op == OP_SWAP) && w_len_nz && w_overlap;
  assign w_last    = (r_idx == (r_len - IDX_ONE));
  assign w_addr_ai = r_addr_a + r_idx[addr_w_N-1:0];
  assign w_addr_bi = r_addr_b + r_idx[addr_w_N-1:0];
  assign w_sel     = port_sel(r_state, r_op);

  assign usr_ready = w_idle;
  assign cmd_ready = w_idle;
  assign busy      = !w_idle;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_NOP;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_fill   <= '0;
      r_tmp_a  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op     <= w_cmd_op;
            r_addr_a <= cmd_addr_a;
            r_addr_b <= cmd_addr_b;
            r_len    <= cmd_len;
            r_fill   <= cmd_fill;
            r_idx    <= '0;
            if (w_cmd_op == OP_FILL && w_len_nz) begin
              r_state <= ST_FILL;
            end else if (w_cmd_op == OP_SWAP && w_len_nz && !w_overlap) begin
              r_state <= ST_RD_A;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= w_reject;
            end
          end
        end
        ST_FILL: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        ST_RD_A: r_state <= ST_RD_B;
        ST_RD_B: begin
          r_tmp_a <= mem_data_r;
          r_state <= ST_WR_A;
        end
        ST_WR_A: r_state <= ST_WR_B;
        ST_WR_B: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + IDX_ONE;
            r_state <= ST_RD_A;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // In WR_A the read port still returns B's word requested during RD_B.
  mem_port_mux #(
    .addr_w_N    (addr_w_N),
    .data_w_Bits (data_w_Bits)
  ) u_port_mux (
    .i_sel         (w_sel),
    .i_usr_we      (usr_we),
    .i_usr_addr_w  (usr_addr_w),
    .i_usr_addr_r  (usr_addr_r),
    .i_usr_data_w  (usr_data_w),
    .i_fill_we     (r_state == ST_FILL),
    .i_fill_addr   (w_addr_ai),
    .i_fill_data_w (r_fill),
    .i_swap_we     ((r_state == ST_WR_A) || (r_state == ST_WR_B)),
    .i_swap_addr_w ((r_state == ST_WR_A) ? w_addr_ai : w_addr_bi),
    .i_swap_addr_r ((r_state == ST_RD_A) ? w_addr_ai : w_addr_bi),
    .i_swap_data_w ((r_state == ST_WR_A) ? mem_data_r : r_tmp_a),
    .o_mem_we      (mem_we),
    .o_mem_addr_w  (mem_addr_w),
    .o_mem_addr_r  (mem_addr_r),
    .o_mem_data_w  (mem_data_w)
  );

endmodule
